ff_stim_chk: RTL and testbench

Stimulus generator and response checker for the single-bit-per-lane positive-edge flop cells in the sequential techmap simulation tests. It wraps the mapped flop bank. It drives a pseudo-random vector stream into the bank's `d` inputs and compares the bank's `q` outputs against the expected one-cycle-delayed stream. It then reports pass/fail, an error count and the first failing vector index.

---
 rtl/ff_stim_chk.sv | 121 ++++++++++++
 tb/tb_ff_stim_chk.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ff_stim_chk.sv
// Stimulus generator and response checker for a bank of single-bit flops:
// drives an LFSR vector stream into d and checks q against the stream one cycle late.

module ff_stim_chk_lane (
  input  logic q,
  input  logic e,
  output logic neq
);
  assign neq = q ^ e;
endmodule

module ff_stim_chk #(
  parameter int          WIDTH   = 8,
  parameter int          NUM_VEC = 64,
  parameter int          IDXW    = 8,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] d_out,
  input  logic [WIDTH-1:0] q_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_cnt,
  output logic [IDXW-1:0]  first_err_idx
);

  typedef enum logic [1:0] {IDLE, DRIVE, FLUSH} state_t;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_VEC - 1);

  state_t            state_q, state_d;
  logic [15:0]       lfsr, lfsr_nxt;
  logic [IDXW-1:0]   idx, exp_idx;
  logic [WIDTH-1:0]  exp_v;
  logic [WIDTH-1:0]  lane_neq;
  logic              chk_valid, err_seen, mismatch, last_vec;

  assign lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign last_vec = (idx == LAST_IDX);

  // Per-lane difference; the vector counts once no matter how many lanes differ.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    ff_stim_chk_lane u_lane (.q(q_in[i]), .e(exp_v[i]), .neq(lane_neq[i]));
  end
  assign mismatch = chk_valid && (|lane_neq);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = DRIVE;
      DRIVE:   if (last_vec) state_d = FLUSH;
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr          <= SEED;
      d_out         <= '0;
      idx           <= '0;
      exp_v         <= '0;
      exp_idx       <= '0;
      chk_valid     <= 1'b0;
      err_seen      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_cnt       <= '0;
      first_err_idx <= '0;
    end else begin
      done <= 1'b0;
      if (state_q != IDLE && mismatch) begin
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        if (!err_seen) begin
          first_err_idx <= exp_idx;
          err_seen      <= 1'b1;
        end
      end
      case (state_q)
        IDLE: if (start) begin
          lfsr          <= SEED;
          d_out         <= SEED[WIDTH-1:0];
          idx           <= '0;
          err_cnt       <= '0;
          first_err_idx <= '0;
          err_seen      <= 1'b0;
          pass          <= 1'b0;
          chk_valid     <= 1'b0;
          busy          <= 1'b1;
        end
        DRIVE: begin
          exp_v     <= d_out;
          exp_idx   <= idx;
          chk_valid <= 1'b1;
          if (!last_vec) begin
            lfsr  <= lfsr_nxt;
            d_out <= lfsr_nxt[WIDTH-1:0];
            idx   <= idx + 1'b1;
          end
        end
        FLUSH: begin
          busy <= 1'b0;
          done <= 1'b1;
          // The flush compare has not landed in err_seen yet, so fold it in here.
          pass <= !(err_seen || mismatch);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ff_stim_chk.sv
// Directed bench for ff_stim_chk with a behavioural flop bank in the loop.

module tb_ff_stim_chk;
  logic       clk = 1'b0;
  logic       rst, start, start2;
  logic [7:0] d_out, q_reg, flip, q_in;
  logic       busy, done, pass;
  logic [7:0] err_cnt, first_err_idx;
  logic [7:0] d_out2, q_reg2, q_in2;
  logic       busy2, done2, pass2;
  logic [7:0] err_cnt2;
  logic [8:0] first_err_idx2;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    q_reg  <= d_out;
    q_reg2 <= d_out2;
  end
  assign q_in  = q_reg ^ flip;
  assign q_in2 = ~q_reg2;

  ff_stim_chk dut (
    .clk(clk), .rst(rst), .start(start), .d_out(d_out), .q_in(q_in),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .first_err_idx(first_err_idx)
  );

  ff_stim_chk #(.WIDTH(8), .NUM_VEC(300), .IDXW(9), .SEED(16'hACE1)) dut_sat (
    .clk(clk), .rst(rst), .start(start2), .d_out(d_out2), .q_in(q_in2),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err_cnt2), .first_err_idx(first_err_idx2)
  );

  // E0: start accepted at this edge.
  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Edges E1..E65; fe1/fe2 flip q_in by fm in the cycle before that edge.
  task automatic run_body(input int fe1, input int fe2, input logic [7:0] fm, input int start_at,
                          output int busy_bad, output int early_done, output logic done_ok,
                          output logic [7:0] s1, output logic [7:0] s2, output logic [7:0] s3);
    busy_bad = 0; early_done = 0; done_ok = 1'b0; s1 = 0; s2 = 0; s3 = 0;
    for (int e = 1; e <= 65; e++) begin
      flip  = (e == fe1 || e == fe2) ? fm : 8'h00;
      start = (e == start_at);
      @(posedge clk); #1;
      flip  = 8'h00;
      start = 1'b0;
      if (e == 1) s1 = d_out;
      if (e == 2) s2 = d_out;
      if (e == 3) s3 = d_out;
      if (e < 65) begin
        if (busy !== 1'b1) busy_bad++;
        if (done !== 1'b0) early_done++;
      end else done_ok = (done === 1'b1) && (busy === 1'b0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; start2 = 1'b1; flip = 8'h00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++;
    if ({d_out, busy, done, pass, err_cnt, first_err_idx} !== 27'd0) begin
      bad++; $display("FAIL reset_held: got d=%h b=%b dn=%b p=%b e=%h f=%h need all 0",
                      d_out, busy, done, pass, err_cnt, first_err_idx);
    end
    rst = 1'b0; start = 1'b0; start2 = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({d_out, busy, done, pass, err_cnt, first_err_idx} !== 27'd0 || busy2 !== 1'b0) begin
      bad++; $display("FAIL reset_release: got d=%h b=%b dn=%b p=%b e=%h f=%h b2=%b need all 0",
                      d_out, busy, done, pass, err_cnt, first_err_idx, busy2);
    end
  endtask

  task automatic test_clean_and_back_to_back();
    int bb, ed; logic dok; logic [7:0] s1, s2, s3;
    do_start();
    total++;
    if (d_out !== 8'hE1 || busy !== 1'b1) begin
      bad++; $display("FAIL clean_e0: got d=%h busy=%b need E1 1", d_out, busy);
    end
    run_body(0, 0, 8'h00, 0, bb, ed, dok, s1, s2, s3);
    total++;
    if ({s1, s2, s3} !== 24'hC3870F) begin
      bad++; $display("FAIL clean_stream: got %h %h %h need c3 87 0f", s1, s2, s3);
    end
    total++;
    if (bb != 0 || ed != 0 || !dok) begin
      bad++; $display("FAIL clean_timing: got busy_bad=%0d early_done=%0d done_ok=%b need 0 0 1", bb, ed, dok);
    end
    total++;
    if (pass !== 1'b1 || err_cnt !== 8'd0) begin
      bad++; $display("FAIL clean_result: got pass=%b err=%0d need 1 0", pass, err_cnt);
    end
    // start during the done cycle: next edge is E0 of a fresh run
    do_start();
    total++;
    if (busy !== 1'b1 || done !== 1'b0 || pass !== 1'b0 || err_cnt !== 8'd0 || d_out !== 8'hE1) begin
      bad++; $display("FAIL b2b_accept: got b=%b dn=%b p=%b e=%0d d=%h need 1 0 0 0 e1",
                      busy, done, pass, err_cnt, d_out);
    end
    run_body(0, 0, 8'h00, 0, bb, ed, dok, s1, s2, s3);
    total++;
    if ({s1, s2, s3} !== 24'hC3870F || bb != 0 || ed != 0 || !dok || pass !== 1'b1) begin
      bad++; $display("FAIL b2b_run: got %h %h %h bb=%0d ed=%0d dok=%b pass=%b need c3 87 0f 0 0 1 1",
                      s1, s2, s3, bb, ed, dok, pass);
    end
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0 || pass !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL result_hold: got dn=%b p=%b b=%b need 0 1 0", done, pass, busy);
    end
  endtask

  task automatic test_single_fault();
    int bb, ed; logic dok; logic [7:0] s1, s2, s3;
    do_start();
    run_body(7, 0, 8'h01, 0, bb, ed, dok, s1, s2, s3);
    total++;
    if (!dok || err_cnt !== 8'd1 || first_err_idx !== 8'd5 || pass !== 1'b0) begin
      bad++; $display("FAIL single_fault: got dok=%b err=%0d first=%0d pass=%b need 1 1 5 0",
                      dok, err_cnt, first_err_idx, pass);
    end
  endtask

  task automatic test_multi_fault();
    int bb, ed; logic dok; logic [7:0] s1, s2, s3;
    do_start();
    run_body(11, 42, 8'hFF, 0, bb, ed, dok, s1, s2, s3);
    total++;
    if (!dok || err_cnt !== 8'd2 || first_err_idx !== 8'd9 || pass !== 1'b0) begin
      bad++; $display("FAIL multi_fault: got dok=%b err=%0d first=%0d pass=%b need 1 2 9 0",
                      dok, err_cnt, first_err_idx, pass);
    end
  endtask

  task automatic test_last_vector_fault();
    int bb, ed; logic dok; logic [7:0] s1, s2, s3;
    do_start();
    run_body(65, 0, 8'h80, 0, bb, ed, dok, s1, s2, s3);
    total++;
    if (!dok || err_cnt !== 8'd1 || first_err_idx !== 8'd63 || pass !== 1'b0) begin
      bad++; $display("FAIL flush_fault: got dok=%b err=%0d first=%0d pass=%b need 1 1 63 0",
                      dok, err_cnt, first_err_idx, pass);
    end
  endtask

  task automatic test_saturation();
    int early = 0; logic dok = 1'b0;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    for (int e = 1; e <= 301; e++) begin
      @(posedge clk); #1;
      if (e < 301 && done2 !== 1'b0) early++;
      if (e == 301) dok = (done2 === 1'b1) && (busy2 === 1'b0);
    end
    total++;
    if (early != 0 || !dok) begin
      bad++; $display("FAIL sat_timing: got early=%0d done_ok=%b need 0 1", early, dok);
    end
    total++;
    if (err_cnt2 !== 8'd255 || first_err_idx2 !== 9'd0 || pass2 !== 1'b0) begin
      bad++; $display("FAIL sat_result: got err=%0d first=%0d pass=%b need 255 0 0",
                      err_cnt2, first_err_idx2, pass2);
    end
  endtask

  task automatic test_control();
    int bb, ed, dseen; logic dok; logic [7:0] s1, s2, s3;
    do_start();
    run_body(0, 0, 8'h00, 10, bb, ed, dok, s1, s2, s3);
    total++;
    if (bb != 0 || ed != 0 || !dok || pass !== 1'b1) begin
      bad++; $display("FAIL start_mid_run: got bb=%0d ed=%0d dok=%b pass=%b need 0 0 1 1", bb, ed, dok, pass);
    end
    do_start();
    for (int e = 1; e <= 20; e++) begin
      rst = (e == 20);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    total++;
    if (busy !== 1'b0 || d_out !== 8'h00 || done !== 1'b0 || pass !== 1'b0 || err_cnt !== 8'd0) begin
      bad++; $display("FAIL rst_mid_run: got b=%b d=%h dn=%b p=%b e=%0d need 0 00 0 0 0",
                      busy, d_out, done, pass, err_cnt);
    end
    dseen = 0;
    for (int e = 0; e < 70; e++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) dseen++;
    end
    total++;
    if (dseen != 0) begin
      bad++; $display("FAIL rst_no_done: got %0d active cycles need 0", dseen);
    end
    do_start();
    run_body(0, 0, 8'h00, 0, bb, ed, dok, s1, s2, s3);
    total++;
    if (s1 !== 8'hC3 || bb != 0 || ed != 0 || !dok || pass !== 1'b1 || err_cnt !== 8'd0) begin
      bad++; $display("FAIL fresh_after_rst: got s1=%h bb=%0d ed=%0d dok=%b p=%b e=%0d need c3 0 0 1 1 0",
                      s1, bb, ed, dok, pass, err_cnt);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start2 = 1'b0; flip = 8'h00;
    test_reset();
    test_clean_and_back_to_back();
    test_single_fault();
    test_multi_fault();
    test_last_vector_fault();
    test_saturation();
    test_control();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
